// File: rtl/irrigation_sequencer.sv
// Irrigation actuator sequencer: synchronizes decision-stage requests and drives the
// sprinkler/drip actuators through a hold-timed, break-before-make, fault-locking FSM.
module irrigation_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int MIN_ON   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ve_req,
  input  logic       bs_req,
  input  logic       vs_req,
  input  logic       al_in,
  input  logic       e_in,
  output logic       valve_in,
  output logic       sprinkler,
  output logic       drip,
  output logic       alarm,
  output logic       error,
  output logic [1:0] state,
  output logic [7:0] time_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPRAY = 2'd1,
    DRIP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       HOLD    = 8'(MIN_ON);

  // Request bundle order: {ve, bs, vs, al, e}.
  logic [4:0] req_meta;
  logic [4:0] req_sync;
  logic       ve_s, bs_s, vs_s, al_s, e_s, fault_s;

  // NOTE: every flop, including the synchronizer stages, clears on the async reset so
  // no stale request can leak into the FSM after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= '0;
      req_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments keep both stages sampling the pre-edge values,
      // which is what makes this a true two-flop shift.
      req_meta <= {ve_req, bs_req, vs_req, al_in, e_in};
      req_sync <= req_meta;
    end
  end

  assign {ve_s, bs_s, vs_s, al_s, e_s} = req_sync;
  assign fault_s = al_s | e_s;

  logic [CNT_W-1:0] presc;
  logic             tick;

  assign tick = (presc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  state_t     state_q;
  logic [7:0] timer;
  logic       lock_run;  // lockout countdown has been loaded since the last fault cleared

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer     <= 8'd0;
      lock_run  <= 1'b0;
      valve_in  <= 1'b0;
      sprinkler <= 1'b0;
      drip      <= 1'b0;
      alarm     <= 1'b0;
      error     <= 1'b0;
    end else begin
      valve_in <= ve_s;
      alarm    <= al_s;
      error    <= e_s;
      if (fault_s) begin
        // A fault overrides any hold in progress and keeps the lockout parked at zero.
        state_q   <= FAULT;
        timer     <= 8'd0;
        lock_run  <= 1'b0;
        sprinkler <= 1'b0;
        drip      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bs_s) begin
              state_q   <= SPRAY;
              timer     <= HOLD;
              sprinkler <= 1'b1;
            end else if (vs_s) begin
              state_q <= DRIP;
              timer   <= HOLD;
              drip    <= 1'b1;
            end
          end
          SPRAY: begin
            if (timer == 8'd0 && !bs_s) begin
              state_q   <= IDLE;
              sprinkler <= 1'b0;
            end else if (tick && timer != 8'd0) begin
              timer <= timer - 8'd1;
            end
          end
          DRIP: begin
            if (timer == 8'd0 && !vs_s) begin
              state_q <= IDLE;
              drip    <= 1'b0;
            end else if (tick && timer != 8'd0) begin
              timer <= timer - 8'd1;
            end
          end
          FAULT: begin
            if (!lock_run) begin
              timer    <= HOLD;
              lock_run <= 1'b1;
            end else if (timer == 8'd0) begin
              state_q  <= IDLE;
              lock_run <= 1'b0;
            end else if (tick) begin
              timer <= timer - 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign state     = state_q;
  assign time_left = timer;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer: a cycle-level behavioural model is checked
// against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_irrigation_sequencer;

  localparam int TICK_DIV = 4;
  localparam int MIN_ON   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ve_req = 1'b0, bs_req = 1'b0, vs_req = 1'b0, al_in = 1'b0, e_in = 1'b0;
  logic       valve_in, sprinkler, drip, alarm, error;
  logic [1:0] state;
  logic [7:0] time_left;

  irrigation_sequencer #(.TICK_DIV(TICK_DIV), .MIN_ON(MIN_ON)) dut (
    .clk(clk), .rst_n(rst_n),
    .ve_req(ve_req), .bs_req(bs_req), .vs_req(vs_req), .al_in(al_in), .e_in(e_in),
    .valve_in(valve_in), .sprinkler(sprinkler), .drip(drip),
    .alarm(alarm), .error(error), .state(state), .time_left(time_left)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Requests reach the FSM two edges after they are sampled; ticks fall on every
  // TICK_DIV-th edge counted from reset release.
  int         m_state, m_timer, m_edges;
  bit         m_lock, m_valve, m_alarm, m_error;
  bit [4:0]   hist[$];
  bit         rst_seen = 1'b0;

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_edges = 0; m_lock = 0;
    m_valve = 0; m_alarm = 0; m_error = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit [4:0] smp);
    bit [4:0] s;
    bit       tick, fault, ve, bs, vs, al, e;
    s = (hist.size() >= 2) ? hist[hist.size() - 2] : 5'd0;
    hist.push_back(smp);
    m_edges++;
    tick = ((m_edges % TICK_DIV) == 0);
    {ve, bs, vs, al, e} = s;
    fault = al | e;
    m_valve = ve; m_alarm = al; m_error = e;
    if (fault) begin
      m_state = 3; m_timer = 0; m_lock = 0;
    end else if (m_state == 0) begin
      if (bs)      begin m_state = 1; m_timer = MIN_ON % 256; end
      else if (vs) begin m_state = 2; m_timer = MIN_ON % 256; end
    end else if (m_state == 1 || m_state == 2) begin
      if (m_timer == 0 && !(m_state == 1 ? bs : vs)) m_state = 0;
      else if (tick && m_timer > 0) m_timer--;
    end else begin
      if (!m_lock) begin m_timer = MIN_ON % 256; m_lock = 1; end
      else if (m_timer == 0) begin m_state = 0; m_lock = 0; end
      else if (tick) m_timer--;
    end
  endtask

  initial forever begin
    @(negedge rst_n);
    rst_seen = 1'b1;
  end

  initial begin : compare_proc
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n || rst_seen) begin
        model_reset();
        rst_seen = 1'b0;
      end
      if (rst_n) model_step({ve_req, bs_req, vs_req, al_in, e_in});
      #1;
      check("m_state", state, m_state);
      check("m_time_left", time_left, m_timer);
      check("m_valve_in", valve_in, m_valve);
      check("m_sprinkler", sprinkler, m_state == 1);
      check("m_drip", drip, m_state == 2);
      check("m_alarm", alarm, m_alarm);
      check("m_error", error, m_error);
      check("no_overlap", sprinkler & drip, 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int n;

  task automatic wait_idle(input string name, input int limit);
    n = 0;
    while (state != 2'd0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, state, 0);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_time_left", time_left, 0);
    check("rst_outputs", {valve_in, sprinkler, drip, alarm, error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) single-cycle sprinkler request: on 3 cycles later, held for ~3 ticks
    bs_req = 1'b1;
    @(negedge clk);
    bs_req = 1'b0;
    repeat (2) @(negedge clk);
    check("s1_sprinkler_on", sprinkler, 1);
    check("s1_time_left_load", time_left, 3);
    n = 0;
    while (sprinkler && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s1_hold_window", (n >= 9 && n <= 15), 1);
    check("s1_back_idle", state, 0);
    check("s1_time_left_zero", time_left, 0);
    repeat (2) @(negedge clk);

    // 2) both requests: spray wins, then one idle cycle, then drip
    bs_req = 1'b1; vs_req = 1'b1;
    repeat (3) @(negedge clk);
    check("s2_spray", state, 1);
    check("s2_no_drip", drip, 0);
    repeat (2) @(negedge clk);
    bs_req = 1'b0;
    n = 0;
    while (state == 2'd1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s2_break_idle", state, 0);
    check("s2_break_outputs", {sprinkler, drip}, 0);
    @(negedge clk);
    check("s2_drip", state, 2);
    check("s2_drip_on", drip, 1);
    vs_req = 1'b0;
    wait_idle("s2_drip_done", 30);
    repeat (2) @(negedge clk);

    // 3) error during spray at time_left=2
    bs_req = 1'b1;
    @(negedge clk);
    bs_req = 1'b0;
    n = 0;
    while (time_left != 8'd2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s3_reach_tl2", time_left, 2);
    e_in = 1'b1;
    repeat (3) @(negedge clk);
    check("s3_fault_state", state, 3);
    check("s3_sprinkler_off", sprinkler, 0);
    check("s3_error_on", error, 1);
    check("s3_time_left", time_left, 0);
    e_in = 1'b0;
    wait_idle("s3_recover", 40);
    repeat (2) @(negedge clk);

    // 4) alarm reasserted at time_left=1 restarts the lockout
    al_in = 1'b1;
    repeat (4) @(negedge clk);
    check("s4_fault", state, 3);
    check("s4_alarm", alarm, 1);
    al_in = 1'b0;
    n = 0;
    while (time_left != 8'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s4_reach_tl1", time_left, 1);
    al_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_stay_fault", state, 3);
    end
    check("s4_timer_cleared", time_left, 0);
    al_in = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s4_relock_window", (n >= 13 && n <= 16), 1);
    check("s4_idle", state, 0);
    repeat (2) @(negedge clk);

    // 5) inlet valve follows its request in FAULT with 3-cycle latency
    e_in = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_fault", state, 3);
    ve_req = 1'b1;
    repeat (2) @(negedge clk);
    check("s5_valve_lag", valve_in, 0);
    @(negedge clk);
    check("s5_valve_on", valve_in, 1);
    ve_req = 1'b0;
    repeat (2) @(negedge clk);
    check("s5_valve_hold", valve_in, 1);
    @(negedge clk);
    check("s5_valve_off", valve_in, 0);
    e_in = 1'b0;
    wait_idle("s5_recover", 40);
    repeat (2) @(negedge clk);

    // 6) asynchronous reset mid-drip
    vs_req = 1'b1; ve_req = 1'b1;
    repeat (5) @(negedge clk);
    check("s6_drip", state, 2);
    check("s6_valve", valve_in, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_state", state, 0);
    check("s6_async_time_left", time_left, 0);
    check("s6_async_outputs", {valve_in, sprinkler, drip, alarm, error}, 0);
    vs_req = 1'b0; ve_req = 1'b0;
    @(negedge clk);
    check("s6_held_state", state, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s6_after_release", {state, sprinkler, drip}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per timing tick (1 s at 50 MHz); legal range 2 or more.
REQ-002 Parameter MIN_ON, default 5, minimum actuator on-time and post-fault lockout, in ticks; legal range 1-255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ve_req  input  1  inlet-valve request from the combinational decision stage; asynchronous to clk.
REQ-006 bs_req  input  1  sprinkler request (gated Bs_Ag level from the decision stage); asynchronous.
REQ-007 vs_req  input  1  drip-valve request; asynchronous.
REQ-008 al_in  input  1  tank alarm; asynchronous.
REQ-009 e_in  input  1  sensor-inconsistency error; asynchronous.
REQ-010 valve_in  output  1  inlet valve drive.
REQ-011 sprinkler  output  1  sprinkler pump drive.
REQ-012 drip  output  1  drip valve drive.
REQ-013 alarm  output  1  alarm indicator.
REQ-014 error  output  1  error indicator.
REQ-015 state  output  2  FSM code: IDLE=0, SPRAY=1, DRIP=2, FAULT=3.
REQ-016 time_left  output  8  current hold/lockout countdown, in ticks.

Function
REQ-017 Each request input SHALL pass through a two-flop synchronizer; all logic below uses only the synchronized copies (suffix _s).
REQ-018 The prescaler SHALL count 0 to TICK_DIV-1 and wrap to 0; tick is asserted for exactly one cycle, the cycle when the count equals TICK_DIV-1.
REQ-019 fault_s is defined as al_s OR e_s; alarm SHALL equal registered al_s, and error SHALL equal registered e_s, in every state.
REQ-020 valve_in SHALL equal registered ve_s in every state; the inlet valve is not interlocked with the FSM.
REQ-021 sprinkler SHALL be 1 only in SPRAY, drip SHALL be 1 only in DRIP, and both SHALL never be 1 in the same cycle.
REQ-022 All outputs SHALL be registered.
REQ-023 IDLE with fault_s: next state FAULT.
REQ-024 IDLE, no fault, bs_s=1: next state SPRAY, load timer with MIN_ON; bs_s has priority over vs_s.
REQ-025 IDLE, no fault, bs_s=0, vs_s=1: next state DRIP, load timer with MIN_ON.
REQ-026 SPRAY and DRIP: decrement the timer by 1 on each tick while it is nonzero; it saturates at 0.
REQ-027 SPRAY: exit to IDLE only when timer=0 and bs_s=0; bs_s returning to 1 while the timer is nonzero has no effect (timer is not reloaded).
REQ-028 DRIP: exit to IDLE only when timer=0 and vs_s=0.
REQ-029 SPRAY to DRIP or DRIP to SPRAY SHALL always pass through at least one IDLE cycle (break-before-make).
REQ-030 Any state with fault_s=1: next state FAULT, timer cleared to 0, regardless of the hold timer; fault takes priority over all other conditions.
REQ-031 FAULT while fault_s=1: timer held at 0.
REQ-032 In the first FAULT cycle with fault_s=0, load MIN_ON; the timer then counts down on ticks, and when it reaches 0 with fault_s=0 the next state is IDLE.
REQ-033 A fault reasserting during the lockout SHALL clear the timer, and the lockout restarts after the fault clears.
REQ-034 time_left SHALL equal the timer register in every state.
REQ-035 The timer is 8 bits wide, and a load with MIN_ON truncates to 8 bits.

Reset
REQ-036 Asserting rst_n=0 SHALL immediately force: state=IDLE, timer=0, prescaler=0, synchronizers=0, and all outputs=0.
REQ-037 Reset mid-operation (any state, any timer value) SHALL abort without completing the hold time.
REQ-038 After rst_n deasserts, the first tick occurs TICK_DIV cycles later.

Verification (TICK_DIV=4, MIN_ON=3)
REQ-039 Bench SHALL run: bs_req pulse 1 cycle in IDLE -> sprinkler=1 three cycles later, held until time_left=0 (3 ticks = 12 cycles, ±3 cycles), then IDLE.
REQ-040 Bench SHALL run: bs_req=1 and vs_req=1 together -> SPRAY only; after bs_req drops and the hold expires, one IDLE cycle, then DRIP; sprinkler and drip never both 1.
REQ-041 Bench SHALL run: e_in=1 during SPRAY with time_left=2 -> state=3, sprinkler=0 and error=1 within 3 cycles, time_left=0.
REQ-042 Bench SHALL run: al_in high, then low, then high again at time_left=1 -> lockout restarts; IDLE is reached only 3 ticks after the final release.
REQ-043 Bench SHALL run: ve_req toggled in FAULT -> valve_in follows with 3-cycle latency.
REQ-044 Bench SHALL run: rst_n pulsed low asynchronously mid-DRIP -> all outputs 0 before the next clock edge, state=0.
